// File: rtl/adder_arbiter_pkg.sv
// Shared types and default sizes for the adder arbiter slice.
// Holds the FSM state enum and default requester/width constants.
package arb_pkg;

   localparam int ARB_N_REQ = 4;
   localparam int ARB_WIDTH = 32;

   typedef enum logic {
      ARB_IDLE,
      ARB_BUSY
   } arb_state_t;

endpackage

// File: rtl/adder_arbiter_if.sv
// Request/response bundle between requesters and the adder arbiter.
// slave: arbiter side, master: requester/consumer side.
interface adder_arbiter_if
   import arb_pkg::*;
#(
   parameter int N_REQ = ARB_N_REQ,
   parameter int WIDTH = ARB_WIDTH,
   parameter int ID_W  = $clog2(N_REQ)
) ();

   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ*WIDTH-1:0] req_a;
   logic [N_REQ*WIDTH-1:0] req_b;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [ID_W-1:0]        rsp_id;
   logic [WIDTH-1:0]       rsp_sum;
   logic                   rsp_carry;

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id,
      output rsp_sum, rsp_carry
   );

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id,
      input  rsp_sum, rsp_carry
   );

endinterface

// File: rtl/adder_arbiter_rr_arbiter.sv
// Round-robin pick: search starts after last and wraps.
// req: requests, last: previous winner, en: allow grant, gnt: one-hot.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  last,
   input  logic             en,
   output logic [N_REQ-1:0] gnt
);

   logic found;

   // outer loop walks priority order, inner loop keeps indices constant
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (en && !found && req[i] &&
                i == (int'(last) + k) % N_REQ) begin
               gnt[i] = 1'b1;
               found  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/fulladder.sv
// Shared unsigned adder used by the datapath.
// a, b: operands; sum: low WIDTH bits; cout: bit WIDTH of the sum.
module fulladder #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   // zero-extended add so the top bit is the unsigned carry
   assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_arbiter.sv
// Shares one adder among N_REQ requesters, round-robin, one op/cycle.
// clk, rst (sync, active-high); bus: request/response bundle (slave).
module adder_arbiter
   import arb_pkg::*;
#(
   parameter int N_REQ = ARB_N_REQ,
   parameter int WIDTH = ARB_WIDTH,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic           clk,
   input  logic           rst,
   adder_arbiter_if.slave bus
);

   localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_REQ - 1);

   arb_state_t       state;
   logic [ID_W-1:0]  last;
   logic [ID_W-1:0]  gidx;
   logic [ID_W-1:0]  id_q;
   logic [N_REQ-1:0] gnt;
   logic             free;
   logic             hs;
   logic [WIDTH-1:0] a_sel;
   logic [WIDTH-1:0] b_sel;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] sum_q;
   logic             carry;
   logic             carry_q;
   logic             valid_q;

   // no grants while in reset so nothing is accepted and lost
   assign free = !rst &&
                 (state == ARB_IDLE || bus.rsp_ready);

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_rr (
      .req  (bus.req_valid),
      .last (last),
      .en   (free),
      .gnt  (gnt)
   );

   // gnt is already qualified by req_valid
   assign hs = |gnt;

   always_comb begin
      gidx  = '0;
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            gidx  = ID_W'(i);
            a_sel = bus.req_a[i*WIDTH +: WIDTH];
            b_sel = bus.req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   fulladder #(
      .WIDTH (WIDTH)
   ) u_add (
      .a    (a_sel),
      .b    (b_sel),
      .sum  (sum),
      .cout (carry)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ARB_IDLE;
         valid_q <= 1'b0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         id_q    <= '0;
         last    <= LAST_RST;
      end else if (hs) begin
         state   <= ARB_BUSY;
         valid_q <= 1'b1;
         sum_q   <= sum;
         carry_q <= carry;
         id_q    <= gidx;
         last    <= gidx;
      end else if (state == ARB_BUSY &&
                   bus.rsp_ready) begin
         state   <= ARB_IDLE;
         valid_q <= 1'b0;
      end
   end

   assign bus.req_ready = gnt;
   assign bus.rsp_valid = valid_q;
   assign bus.rsp_sum   = sum_q;
   assign bus.rsp_carry = carry_q;
   assign bus.rsp_id    = id_q;

endmodule
